flash_pe_ctrl: RTL and testbench

FLASH_PE_CTRL -- requirements
Module: flash_pe_ctrl

---
 rtl/flash_pe_ctrl.sv | 153 +++++++++++++++
 tb/tb_flash_pe_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/flash_pe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : flash_pe_ctrl
// Brief   : Flash program/erase sequencer: analog settle, periodic write
//           strobes, and erase/erase-clear phases.
// Revision: 1.0
// ============================================================================
module flash_pe_ctrl #(
    parameter int SETUP_CYCLES = 4,
    parameter int PROG_PERIOD  = 2,
    parameter int ERASE_CYCLES = 8,
    parameter int CLR_CYCLES   = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clkm,
    input  logic             rst_n,
    input  logic             program_signal,
    input  logic             erase_signal,
    input  logic             cs,
    output logic             en_wr,
    output logic             erase,
    output logic             erase_clr,
    output logic             analog_on2,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] wr_count
);

    localparam int c_MAX_A   = (SETUP_CYCLES > PROG_PERIOD) ? SETUP_CYCLES : PROG_PERIOD;
    localparam int c_MAX_B   = (ERASE_CYCLES > CLR_CYCLES) ? ERASE_CYCLES : CLR_CYCLES;
    localparam int c_TMR_MAX = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [c_TMR_W-1:0] c_SETUP_LD  = c_TMR_W'(SETUP_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_WAIT_LD   = c_TMR_W'(PROG_PERIOD - 2);
    localparam logic [c_TMR_W-1:0] c_ERASE_LD  = c_TMR_W'(ERASE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_CLR_LD    = c_TMR_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SETUP      = 3'd1,
        S_PROG_WAIT  = 3'd2,
        S_PROG_PULSE = 3'd3,
        S_ERASE      = 3'd4,
        S_ERASE_CLR  = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_TMR_W-1:0] w_timer_nxt;
    logic               r_mode_erase;
    logic               w_mode_erase_nxt;
    logic [CNT_W-1:0]   r_wr_count;
    logic [CNT_W-1:0]   w_wr_count_nxt;

    always_ff @(posedge clkm or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_mode_erase <= 1'b0;
            r_wr_count   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_mode_erase <= w_mode_erase_nxt;
            r_wr_count   <= w_wr_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = (r_timer != '0) ? (r_timer - c_TMR_ONE) : r_timer;
        w_mode_erase_nxt = r_mode_erase;
        w_wr_count_nxt   = r_wr_count;
        case (r_state)
            S_IDLE: begin
                if (cs && program_signal) begin
                    w_state_nxt      = S_SETUP;
                    w_timer_nxt      = c_SETUP_LD;
                    w_mode_erase_nxt = 1'b0;
                    w_wr_count_nxt   = '0;
                end else if (cs && erase_signal) begin
                    w_state_nxt      = S_SETUP;
                    w_timer_nxt      = c_SETUP_LD;
                    w_mode_erase_nxt = 1'b1;
                end
            end
            S_SETUP: begin
                if (!r_mode_erase && !program_signal) begin
                    w_state_nxt = S_DONE;
                end else if (r_timer == '0) begin
                    if (r_mode_erase) begin
                        w_state_nxt = S_ERASE;
                        w_timer_nxt = c_ERASE_LD;
                    end else begin
                        w_state_nxt = S_PROG_WAIT;
                        w_timer_nxt = c_WAIT_LD;
                    end
                end
            end
            S_PROG_WAIT: begin
                if (!program_signal) begin
                    w_state_nxt = S_DONE;
                end else if (r_timer == '0) begin
                    w_state_nxt = S_PROG_PULSE;
                end
            end
            S_PROG_PULSE: begin
                // The strobe of an entered pulse cycle is always counted, even on abort.
                w_wr_count_nxt = (&r_wr_count) ? r_wr_count : (r_wr_count + c_CNT_ONE);
                if (!program_signal) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_PROG_WAIT;
                    w_timer_nxt = c_WAIT_LD;
                end
            end
            S_ERASE: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_ERASE_CLR;
                    w_timer_nxt = c_CLR_LD;
                end
            end
            S_ERASE_CLR: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy       = (r_state == S_SETUP) || (r_state == S_PROG_WAIT) ||
                        (r_state == S_PROG_PULSE) || (r_state == S_ERASE) ||
                        (r_state == S_ERASE_CLR);
    assign analog_on2 = busy;
    assign en_wr      = (r_state == S_PROG_PULSE);
    assign erase      = (r_state == S_ERASE) || (r_state == S_ERASE_CLR);
    assign erase_clr  = (r_state == S_ERASE_CLR);
    assign done       = (r_state == S_DONE);
    assign wr_count   = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_flash_pe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_flash_pe_ctrl
// Brief   : Directed plus random bench for flash_pe_ctrl against an
//           elapsed-cycle reference model.
// Revision: 1.0
// ============================================================================
module tb_flash_pe_ctrl;

    localparam int SU = 4;
    localparam int PP = 2;
    localparam int ER = 8;
    localparam int CL = 2;

    logic       clkm = 1'b0;
    logic       rst_n = 1'b0;
    logic       program_signal = 1'b0;
    logic       erase_signal = 1'b0;
    logic       cs = 1'b0;
    logic       en_wr, erase, erase_clr, analog_on2, busy, done;
    logic [7:0] wr_count;
    logic       en_wr_s, erase_s, erase_clr_s, analog_on2_s, busy_s, done_s;
    logic [1:0] wr_count_s;

    int vectors = 0;
    int miscompares = 0;

    // Model: operation kind (0 idle, 1 program, 2 erase, 3 done) and cycles since start.
    int m_op = 0;
    int m_k = 0;
    int m_cnt = 0;
    int m_cnt_s = 0;

    always #5 clkm = ~clkm;

    flash_pe_ctrl dut (
        .clkm(clkm), .rst_n(rst_n), .program_signal(program_signal),
        .erase_signal(erase_signal), .cs(cs), .en_wr(en_wr), .erase(erase),
        .erase_clr(erase_clr), .analog_on2(analog_on2), .busy(busy),
        .done(done), .wr_count(wr_count)
    );

    flash_pe_ctrl #(.CNT_W(2)) dut_sat (
        .clkm(clkm), .rst_n(rst_n), .program_signal(program_signal),
        .erase_signal(erase_signal), .cs(cs), .en_wr(en_wr_s), .erase(erase_s),
        .erase_clr(erase_clr_s), .analog_on2(analog_on2_s), .busy(busy_s),
        .done(done_s), .wr_count(wr_count_s)
    );

    // Expected {en_wr, erase, erase_clr, analog_on2, busy, done}.
    function automatic logic [5:0] exp_out();
        logic [5:0] o;
        o = 6'b0;
        if (m_op == 1) begin
            o[2] = 1'b1;
            o[1] = 1'b1;
            o[5] = (m_k >= SU) && (((m_k - SU) % PP) == PP - 1);
        end else if (m_op == 2) begin
            o[2] = 1'b1;
            o[1] = 1'b1;
            o[4] = (m_k >= SU);
            o[3] = (m_k >= SU + ER);
        end else if (m_op == 3) begin
            o[0] = 1'b1;
        end
        return o;
    endfunction

    task automatic model_reset();
        m_op = 0;
        m_k = 0;
        m_cnt = 0;
        m_cnt_s = 0;
    endtask

    task automatic model_edge();
        logic [5:0] o;
        o = exp_out();
        case (m_op)
            0: begin
                if (cs && program_signal) begin
                    m_op = 1; m_k = 0; m_cnt = 0; m_cnt_s = 0;
                end else if (cs && erase_signal) begin
                    m_op = 2; m_k = 0;
                end
            end
            1: begin
                if (o[5]) begin
                    m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
                    m_cnt_s = (m_cnt_s < 3) ? m_cnt_s + 1 : 3;
                end
                if (!program_signal) m_op = 3;
                else m_k++;
            end
            2: begin
                if (m_k == SU + ER + CL - 1) m_op = 3;
                else m_k++;
            end
            default: m_op = 0;
        endcase
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("strobes", {2'b0, en_wr, erase, erase_clr, analog_on2, busy, done}, {2'b0, exp_out()});
        chk("strobes_sat", {2'b0, en_wr_s, erase_s, erase_clr_s, analog_on2_s, busy_s, done_s},
            {2'b0, exp_out()});
        chk("wr_count", wr_count, 8'(m_cnt));
        chk("wr_count_sat", {6'b0, wr_count_s}, 8'(m_cnt_s));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clkm);
            if (!rst_n) model_reset();
            else model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic drive(input logic c, input logic p, input logic e);
        cs = c;
        program_signal = p;
        erase_signal = e;
    endtask

    initial begin
        // Reset state
        model_reset();
        #2;
        check_all();
        step(2);

        // Release and request together: first edge after release must accept
        rst_n = 1'b1;
        drive(1, 1, 0);
        step(20);
        drive(0, 0, 0);
        step(4);

        // Abort after two strobes: drop present in cycle 9
        drive(1, 1, 0);
        step(9);
        drive(1, 0, 0);
        step(1);
        chk("abort_done", {7'b0, done}, 8'd1);
        chk("abort_count", wr_count, 8'd2);
        drive(0, 0, 0);
        step(3);

        // Erase with one-cycle request, then attempts to disturb it
        drive(1, 0, 1);
        step(1);
        drive(0, 0, 0);
        step(6);
        drive(1, 1, 1);
        step(4);
        drive(0, 0, 0);
        step(8);

        // Unqualified requests ignored, then program wins priority
        drive(0, 1, 1);
        step(5);
        drive(1, 1, 1);
        step(12);
        drive(0, 0, 0);
        step(3);

        // Asynchronous reset in the middle of an erase
        drive(1, 0, 1);
        step(1);
        drive(0, 0, 0);
        step(7);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_erase", {2'b0, erase, analog_on2, busy, erase_s, analog_on2_s, busy_s}, 8'd0);
        check_all();
        step(2);
        rst_n = 1'b1;
        step(2);

        // Saturation: program held through more than six strobes
        drive(1, 1, 0);
        step(22);
        chk("sat_count", {6'b0, wr_count_s}, 8'd3);
        drive(0, 0, 0);
        step(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cs = ($urandom_range(0, 3) != 0);
            erase_signal = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) program_signal = ~program_signal;
            step(1);
        end
        drive(0, 0, 0);
        step(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
